// File: rtl/hdmi_i2c_target.sv
// I2C target standing in for the HDMI transmitter register port: 256x8 register file,
// auto-incrementing pointer, write-1-to-clear interrupt status register driving int_n.
module hdmi_i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h39,
  parameter logic [7:0]  INT_REG  = 8'h96,
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       int_n,
  input  logic       hpd_event,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);
  localparam int unsigned SL    = (SYNC_LEN < 2) ? 2 : SYNC_LEN;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [SL-1:0]    scl_sync, sda_sync;
  logic             scl_s, sda_s, scl_p, sda_p;
  logic             start_c, stop_c, rise_c, fall_c;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d, ptr_q, ptr_d;
  logic             rw_q, rw_d, ack_q, ack_d, sda_oe_d, busy_d;
  logic [7:0]       shifted_c, rd_byte_c, int_clr_c;
  logic             wr_en_c;
  logic [7:0]       regs [256];

  // Pin synchronisers; reset to the idle-bus level so release creates no edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SL-2:0], scl_i};
      sda_sync <= {sda_sync[SL-2:0], sda_i};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SL-1];
  assign sda_s     = sda_sync[SL-1];
  assign start_c   = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_c    = scl_s & scl_p & ~sda_p & sda_s;
  assign rise_c    = scl_s & ~scl_p;
  assign fall_c    = ~scl_s & scl_p;
  assign shifted_c = {shift_q[6:0], sda_s};
  assign rd_byte_c = regs[ptr_q];
  assign int_clr_c = (wr_en_c && ptr_q == INT_REG) ? shifted_c : 8'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      sda_oe  <= sda_oe_d;
      busy    <= busy_d;
    end
  end

  // Bus protocol: byte shifting on SCL rise, SDA drive changes on SCL fall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    sda_oe_d = sda_oe;
    busy_d   = busy;
    wr_en_c  = 1'b0;
    if (start_c) begin
      state_d  = S_DEV_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
          if (rise_c && cnt_q < CNT_W'(8)) begin
            shift_d = shifted_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              if (state_q == S_DEV_ADDR) begin
                if (shifted_c[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = shifted_c[0];
                end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_REG_ADDR) begin
                ptr_d = shifted_c;
              end else begin
                wr_en_c = 1'b1;
                ptr_d   = ptr_q + 8'd1;
              end
            end
          end else if (fall_c && cnt_q == CNT_W'(8)) begin
            sda_oe_d = 1'b1;
            state_d  = (state_q == S_DEV_ADDR) ? S_DEV_ACK :
                       (state_q == S_REG_ADDR) ? S_REG_ACK : S_WR_ACK;
          end
        end
        S_DEV_ACK: begin
          if (fall_c) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d  = S_RD_DATA;
              shift_d  = rd_byte_c;
              sda_oe_d = ~rd_byte_c[7];
            end else begin
              state_d  = S_REG_ADDR;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_REG_ACK, S_WR_ACK: begin
          if (fall_c) begin
            state_d  = S_WR_DATA;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
        S_RD_DATA: begin
          if (rise_c && cnt_q < CNT_W'(8)) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = {shift_q[6:0], 1'b0};
            if (cnt_q == CNT_W'(7)) ptr_d = ptr_q + 8'd1;
          end else if (fall_c) begin
            if (cnt_q == CNT_W'(8)) begin
              state_d  = S_RD_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        S_RD_ACK: begin
          if (rise_c) begin
            ack_d = ~sda_s;
          end else if (fall_c) begin
            cnt_d = '0;
            if (ack_q) begin
              state_d  = S_RD_DATA;
              shift_d  = rd_byte_c;
              sda_oe_d = ~rd_byte_c[7];
            end else begin
              state_d  = S_IGNORE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register file; the interrupt register clears written ones, and a concurrent hpd set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) regs[i] <= '0;
    end else begin
      if (wr_en_c && ptr_q != INT_REG) regs[ptr_q] <= shifted_c;
      regs[INT_REG] <= (regs[INT_REG] & ~int_clr_c) | {hpd_event, 7'd0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      int_n       <= 1'b1;
      dbg_data    <= '0;
    end else begin
      reg_wr_en <= wr_en_c;
      if (wr_en_c) begin
        reg_wr_addr <= ptr_q;
        reg_wr_data <= shifted_c;
      end
      int_n    <= ~|regs[INT_REG];
      dbg_data <= regs[dbg_addr];
    end
  end
endmodule
